// File: rtl/busy_rr_sched.sv
// Round-robin scheduler for one shared timed resource.
// The resource is granted to one requester at a time. A down-counter times the
// job, and the owner then gets a one-cycle done pulse. An optional idle gap
// follows before the next arbitration.
module busy_rr_sched #(
  parameter int NREQ       = 4,
  parameter int LGDUR      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*LGDUR-1:0]   i_dur,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_owner,
  output logic                    o_busy,
  output logic [NREQ-1:0]         o_done
);

  localparam int OW = $clog2(NREQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [LGDUR-1:0]  cnt_q;
  logic [GW-1:0]     gap_q;
  logic [OW-1:0]     ptr_q;
  logic [OW-1:0]     owner_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;

  logic [NREQ-1:0]   elig_d;
  logic              arb_hit_d;
  logic [OW-1:0]     arb_idx_d;
  logic [LGDUR-1:0]  arb_dur_d;
  logic [LGDUR-1:0]  arb_load_d;
  logic              arb_en_d;

  // Cyclic index starting at the round-robin pointer.
  function automatic int wrap_idx(input logic [OW-1:0] p, input int off);
    return (int'(p) + off) % NREQ;
  endfunction

  // Arbiter: first eligible requester at or after the pointer. While leaving
  // DONE the finishing owner still holds its request as part of the old
  // handshake, so it is not treated as a new job in that cycle.
  always_comb begin
    elig_d = i_req;
    if (state_q == S_DONE) elig_d[owner_q] = 1'b0;
    arb_hit_d = 1'b0;
    arb_idx_d = '0;
    arb_dur_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_d[wrap_idx(ptr_q, i)]) begin
        arb_hit_d = 1'b1;
        arb_idx_d = OW'(wrap_idx(ptr_q, i));
        arb_dur_d = i_dur[wrap_idx(ptr_q, i)*LGDUR +: LGDUR];
      end
    end
  end

  // A zero duration behaves as one cycle; the counter holds cycles-left minus one.
  assign arb_load_d = (arb_dur_d == '0) ? '0 : arb_dur_d - LGDUR'(1);

  // Arbitration happens in IDLE and on the last non-busy cycle after a job, so
  // back-to-back grants are spaced by dur + 1 + GAP_CYCLES.
  assign arb_en_d = (state_q == S_IDLE) ||
                    ((state_q == S_DONE) && (GAP_CYCLES == 0)) ||
                    ((state_q == S_GAP) && (gap_q == '0));

  // Scheduler state machine with registered grant/done/owner outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      if (state_q == S_RUN) begin
        if (cnt_q == '0) begin
          state_q <= S_DONE;
          grant_q <= '0;
          done_q  <= grant_q;
          ptr_q   <= (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end else if (arb_en_d) begin
        if (arb_hit_d) begin
          state_q <= S_RUN;
          grant_q <= NREQ'(1) << arb_idx_d;
          owner_q <= arb_idx_d;
          cnt_q   <= arb_load_d;
        end else begin
          state_q <= S_IDLE;
        end
      end else if (state_q == S_DONE) begin
        state_q <= S_GAP;
        gap_q   <= GAP_INIT;
      end else begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  assign o_grant = grant_q;
  assign o_owner = owner_q;
  assign o_busy  = (state_q == S_RUN);
  assign o_done  = done_q;

endmodule

// File: tb/tb_busy_rr_sched.sv
// Bench for busy_rr_sched: two instances (no gap, gap of 2) checked every
// cycle against a job-level model built from remaining-cycle counts.
module tb_busy_rr_sched;

  typedef struct packed {
    int   busy_left;
    int   blocked;
    int   owner;
    int   ptr;
    logic done;
  } model_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [3:0]  req [2];
  logic [63:0] dur [2];
  logic [3:0]  grant_w [2];
  logic [3:0]  done_w [2];
  logic [1:0]  owner_w [2];
  logic        busy_w [2];

  bit          hs [2];
  logic [3:0]  drop_pend [2];
  model_t      m [2];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  busy_rr_sched #(.NREQ(4), .LGDUR(16), .GAP_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_req(req[0]), .i_dur(dur[0]),
    .o_grant(grant_w[0]), .o_owner(owner_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

  busy_rr_sched #(.NREQ(4), .LGDUR(16), .GAP_CYCLES(2)) dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_req(req[1]), .i_dur(dur[1]),
    .o_grant(grant_w[1]), .o_owner(owner_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

  // Job-level reference: a job occupies max(dur,1) busy cycles, then one done
  // cycle plus gap cycles during which nobody new is picked.
  function automatic model_t model_next(input model_t mm, input logic [3:0] rq,
                                        input logic [63:0] du, input logic rs, input int gap);
    model_t n;
    logic [3:0] elig;
    bit found;
    int k;
    n = mm;
    found = 1'b0;
    if (rs) return '0;
    if (mm.busy_left > 0) begin
      n.busy_left = mm.busy_left - 1;
      if (n.busy_left == 0) begin
        n.done = 1'b1;
        n.ptr = (mm.owner + 1) % 4;
        n.blocked = 1 + gap;
      end
    end else begin
      n.done = 1'b0;
      if (mm.blocked > 1) begin
        n.blocked = mm.blocked - 1;
      end else begin
        n.blocked = 0;
        elig = rq;
        if (mm.done) elig[mm.owner] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          k = (mm.ptr + i) % 4;
          if (!found && elig[k]) begin
            found = 1'b1;
            n.owner = k;
            n.busy_left = (du[k*16 +: 16] == 16'd0) ? 1 : int'(du[k*16 +: 16]);
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] exp_of(input model_t mm);
    logic [3:0] g;
    logic [3:0] dn;
    logic b;
    b  = (mm.busy_left > 0);
    g  = b ? (4'b0001 << mm.owner) : 4'b0000;
    dn = mm.done ? (4'b0001 << mm.owner) : 4'b0000;
    return {g, mm.owner[1:0], b, dn};
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    m[0] <= model_next(m[0], req[0], dur[0], rst[0], 0);
    m[1] <= model_next(m[1], req[1], dur[1], rst[1], 2);
  end

  // Advance to the sampling edge; requesters with handshake enabled drop
  // their request the cycle after seeing their done pulse.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (hs[d]) begin
        for (int k = 0; k < 4; k++)
          if (drop_pend[d][k]) req[d][k] = 1'b0;
        drop_pend[d] = done_w[d];
      end
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({grant_w[d], owner_w[d], busy_w[d], done_w[d]} !== 11'd0) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %h want %h", d,
                 {grant_w[d], owner_w[d], busy_w[d], done_w[d]}, 11'd0);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    hs[0] = 1'b1;
    req[0] = 4'b0001;
    dur[0] = 64'd3;
    for (int i = 1; i <= 6; i++) begin
      tick();
      eg = (i <= 3) ? 4'b0001 : 4'b0000;
      ed = (i == 4) ? 4'b0001 : 4'b0000;
      vectors++;
      if ({grant_w[0], busy_w[0], done_w[0]} !== {eg, (i <= 3), ed}) begin
        miscompares++;
        $display("FAIL single step%0d: got g=%b b=%b d=%b want g=%b b=%b d=%b", i,
                 grant_w[0], busy_w[0], done_w[0], eg, (i <= 3), ed);
      end
      vectors++;
      if ({grant_w[0], owner_w[0], busy_w[0], done_w[0]} !== exp_of(m[0])) begin
        miscompares++;
        $display("FAIL single_model cyc%0d: got %h want %h", cyc,
                 {grant_w[0], owner_w[0], busy_w[0], done_w[0]}, exp_of(m[0]));
      end
    end
  endtask

  task automatic test_rr_order();
    int exp_own [5] = '{0, 1, 2, 3, 0};
    int got_own [5];
    int got_t [5];
    int n;
    logic prev_busy;
    hs[0] = 1'b0;
    rst[0] = 1'b1;
    req[0] = 4'b1111;
    dur[0] = 64'h0002_0002_0002_0002;
    tick();
    rst[0] = 1'b0;
    n = 0;
    prev_busy = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      vectors++;
      if ({grant_w[0], owner_w[0], busy_w[0], done_w[0]} !== exp_of(m[0])) begin
        miscompares++;
        $display("FAIL rr_model cyc%0d: got %h want %h", cyc,
                 {grant_w[0], owner_w[0], busy_w[0], done_w[0]}, exp_of(m[0]));
      end
      if (busy_w[0] && !prev_busy && n < 5) begin
        got_own[n] = int'(owner_w[0]);
        got_t[n] = i;
        n++;
      end
      prev_busy = busy_w[0];
    end
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL rr_count: got %0d grants want 5", n);
    end else begin
      for (int j = 0; j < 5; j++) begin
        vectors++;
        if (got_own[j] !== exp_own[j]) begin
          miscompares++;
          $display("FAIL rr_owner #%0d: got %0d want %0d", j, got_own[j], exp_own[j]);
        end
        if (j > 0) begin
          vectors++;
          if (got_t[j] - got_t[j-1] !== 3) begin
            miscompares++;
            $display("FAIL rr_spacing #%0d: got %0d want 3", j, got_t[j] - got_t[j-1]);
          end
        end
      end
    end
    req[0] = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_ptr_wrap();
    int own [2];
    int n;
    bit seen;
    logic prev_busy;
    hs[0] = 1'b1;
    drop_pend[0] = 4'b0000;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    req[0] = 4'b0001;
    dur[0] = 64'h0001_0001_0001_0001;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (done_w[0][0]) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wrap_first_done: got none want done[0] within 10 cycles");
    end
    tick();
    req[0] = 4'b0101;
    n = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if ({grant_w[0], owner_w[0], busy_w[0], done_w[0]} !== exp_of(m[0])) begin
        miscompares++;
        $display("FAIL wrap_model cyc%0d: got %h want %h", cyc,
                 {grant_w[0], owner_w[0], busy_w[0], done_w[0]}, exp_of(m[0]));
      end
      if (busy_w[0] && !prev_busy && n < 2) begin
        own[n] = int'(owner_w[0]);
        n++;
      end
      prev_busy = busy_w[0];
    end
    vectors++;
    if (n !== 2 || own[0] !== 2 || own[1] !== 0) begin
      miscompares++;
      $display("FAIL wrap_order: got n=%0d owners %0d,%0d want 2 grants owners 2,0",
               n, own[0], own[1]);
    end
  endtask

  task automatic run_dur(input logic [15:0] dv, input int want, input int bound);
    int cnt;
    bit got;
    hs[0] = 1'b1;
    dur[0] = {16'd0, 16'd0, dv, 16'd0};
    req[0] = 4'b0010;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      vectors++;
      if ({grant_w[0], owner_w[0], busy_w[0], done_w[0]} !== exp_of(m[0])) begin
        miscompares++;
        $display("FAIL dur_model cyc%0d: got %h want %h", cyc,
                 {grant_w[0], owner_w[0], busy_w[0], done_w[0]}, exp_of(m[0]));
      end
      if (busy_w[0]) cnt++;
      if (done_w[0][1]) got = 1'b1;
    end
    vectors++;
    if (!got || cnt !== want) begin
      miscompares++;
      $display("FAIL dur_%h: got done=%0d busy=%0d want done=1 busy=%0d", dv, got, cnt, want);
    end
    tick();
  endtask

  task automatic test_dur_edges();
    run_dur(16'h0000, 1, 10);
    run_dur(16'hFFFF, 65535, 70000);
  endtask

  task automatic test_reset_abort();
    hs[0] = 1'b1;
    req[0] = 4'b1000;
    dur[0] = 64'd10 << 48;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (grant_w[0] !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_grant: got %b want 1000", grant_w[0]);
    end
    rst[0] = 1'b1;
    req[0] = 4'b1001;
    tick();
    rst[0] = 1'b0;
    vectors++;
    if ({grant_w[0], owner_w[0], busy_w[0], done_w[0]} !== 11'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %h want 000", {grant_w[0], owner_w[0], busy_w[0], done_w[0]});
    end
    tick();
    vectors++;
    if ({grant_w[0], owner_w[0], done_w[0]} !== {4'b0001, 2'd0, 4'b0000}) begin
      miscompares++;
      $display("FAIL abort_regrant: got g=%b own=%0d d=%b want g=0001 own=0 d=0000",
               grant_w[0], owner_w[0], done_w[0]);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      vectors++;
      if ({grant_w[0], owner_w[0], busy_w[0], done_w[0]} !== exp_of(m[0])) begin
        miscompares++;
        $display("FAIL abort_model cyc%0d: got %h want %h", cyc,
                 {grant_w[0], owner_w[0], busy_w[0], done_w[0]}, exp_of(m[0]));
      end
    end
  endtask

  task automatic test_gap();
    int nb;
    int gaps;
    bit seen;
    hs[1] = 1'b0;
    req[1] = 4'b0011;
    nb = 0;
    gaps = 0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < 4; k++) dur[1][k*16 +: 16] = 16'($urandom_range(1, 4));
      tick();
      vectors++;
      if ({grant_w[1], owner_w[1], busy_w[1], done_w[1]} !== exp_of(m[1])) begin
        miscompares++;
        $display("FAIL gap_model cyc%0d: got %h want %h", cyc,
                 {grant_w[1], owner_w[1], busy_w[1], done_w[1]}, exp_of(m[1]));
      end
      if (busy_w[1]) begin
        if (seen && nb > 0) begin
          gaps++;
          vectors++;
          if (nb !== 3) begin
            miscompares++;
            $display("FAIL gap_len cyc%0d: got %0d idle cycles want 3", cyc, nb);
          end
        end
        seen = 1'b1;
        nb = 0;
        req[1][3:2] = 2'($urandom_range(0, 3));
      end else begin
        nb++;
        req[1][3:2] = 2'b00;
      end
    end
    vectors++;
    if (gaps < 3) begin
      miscompares++;
      $display("FAIL gap_count: got %0d gaps want at least 3", gaps);
    end
  endtask

  task automatic test_random();
    hs[0] = 1'b1; hs[1] = 1'b1;
    req[1] = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 299) == 0);
        for (int k = 0; k < 4; k++) begin
          dur[d][k*16 +: 16] = 16'($urandom_range(0, 6));
          if (!req[d][k] && !drop_pend[d][k] && $urandom_range(0, 3) == 0) req[d][k] = 1'b1;
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if ({grant_w[d], owner_w[d], busy_w[d], done_w[d]} !== exp_of(m[d])) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d: got %h want %h", d, cyc,
                   {grant_w[d], owner_w[d], busy_w[d], done_w[d]}, exp_of(m[d]));
        end
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req[d] = 4'b0000;
      dur[d] = 64'd0;
      hs[d] = 1'b0;
      drop_pend[d] = 4'b0000;
    end
    test_reset();
    test_single();
    test_rr_order();
    test_ptr_wrap();
    test_dur_edges();
    test_reset_abort();
    test_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "watchdog");
  end

endmodule
